// File: rtl/table_fsm_engine_pkg.sv
// Shared types and default sizing for the table-driven Mealy automaton engine.
package table_fsm_engine_pkg;

  localparam int DEF_STATE_W     = 4;
  localparam int DEF_IN_W        = 2;
  localparam int DEF_OUT_W       = 9;
  localparam int DEF_NUM_STATES  = 11;
  localparam int DEF_RESET_STATE = 0;

  typedef enum logic [1:0] {
    MODE_PROG = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_HALT = 2'd2
  } mode_t;

endpackage

// File: rtl/table_fsm_engine_if.sv
// Bus bundle for table_fsm_engine: automaton inputs, run control, table programming and status.
// Defining FSM_TRACE_EN adds the trans_cnt / last_state_o trace signals.
interface table_fsm_engine_if #(
  parameter int STATE_W = table_fsm_engine_pkg::DEF_STATE_W,
  parameter int IN_W    = table_fsm_engine_pkg::DEF_IN_W,
  parameter int OUT_W   = table_fsm_engine_pkg::DEF_OUT_W
);

  logic [IN_W-1:0]          x_in;
  logic                     start_i;
  logic                     stop_i;
  logic                     step_i;
  logic                     prog_we;
  logic [STATE_W+IN_W-1:0]  prog_addr;
  logic [STATE_W+OUT_W-1:0] prog_data;
  logic [OUT_W-1:0]         t_out;
  logic                     t_valid;
  logic [STATE_W-1:0]       state_o;
  logic [1:0]               mode_o;
  logic                     ill_err;
  logic                     prog_err;
`ifdef FSM_TRACE_EN
  logic [15:0]              trans_cnt;
  logic [STATE_W-1:0]       last_state_o;
`endif

  modport master (
    output x_in, start_i, stop_i, step_i, prog_we, prog_addr, prog_data,
    input  t_out, t_valid, state_o, mode_o, ill_err, prog_err
`ifdef FSM_TRACE_EN
    , input trans_cnt, last_state_o
`endif
  );

  modport slave (
    input  x_in, start_i, stop_i, step_i, prog_we, prog_addr, prog_data,
    output t_out, t_valid, state_o, mode_o, ill_err, prog_err
`ifdef FSM_TRACE_EN
    , output trans_cnt, last_state_o
`endif
  );

endinterface

// File: rtl/table_fsm_engine_ram.sv
// Transition table storage: synchronous write, asynchronous read, contents never reset.
module table_fsm_engine_ram #(
  parameter int AW = 6,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/table_fsm_engine.sv
// Programmable table-driven Mealy automaton with PROG/RUN/HALT control and illegal-state recovery.
// Defining FSM_TRACE_EN adds an advance counter and the previous-state trace register.
module table_fsm_engine import table_fsm_engine_pkg::*; #(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int NUM_STATES  = DEF_NUM_STATES,
  parameter int RESET_STATE = DEF_RESET_STATE
) (
  input logic               clk,
  input logic               res,
  table_fsm_engine_if.slave bus
);

  localparam int                 AW      = STATE_W + IN_W;
  localparam int                 DW      = STATE_W + OUT_W;
  localparam logic [STATE_W:0]   NUM_LIM = NUM_STATES[STATE_W:0];
  localparam logic [STATE_W-1:0] RST_ST  = RESET_STATE[STATE_W-1:0];

  mode_t              mode;
  logic [STATE_W-1:0] state;
  logic [DW-1:0]      entry;
  logic [STATE_W-1:0] nxt;
  logic               advance;
  logic               illegal;
  logic               ram_we;
  logic               ill_err;
  logic               prog_err;

  table_fsm_engine_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr ({state, bus.x_in}),
    .rdata (entry)
  );

  // In HALT a step only counts when neither stop nor start claims the cycle.
  assign advance = (mode == MODE_RUN) ||
                   ((mode == MODE_HALT) && bus.step_i && !bus.stop_i && !bus.start_i);
  assign nxt     = entry[DW-1:OUT_W];
  assign illegal = {1'b0, nxt} >= NUM_LIM;
  assign ram_we  = bus.prog_we && (mode == MODE_PROG);

  assign bus.t_out    = advance ? entry[OUT_W-1:0] : '0;
  assign bus.t_valid  = advance;
  assign bus.state_o  = state;
  assign bus.mode_o   = mode;
  assign bus.ill_err  = ill_err;
  assign bus.prog_err = prog_err;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mode     <= MODE_PROG;
      state    <= RST_ST;
      ill_err  <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      if (bus.prog_we && (mode != MODE_PROG)) begin
        prog_err <= 1'b1;
      end
      if (advance) begin
        if (illegal) begin
          state   <= RST_ST;
          ill_err <= 1'b1;
        end else begin
          state <= nxt;
        end
      end
      // Mode changes come last so their state reloads win over any advance.
      case (mode)
        MODE_PROG: begin
          if (bus.start_i) begin
            mode  <= MODE_RUN;
            state <= RST_ST;
          end
        end
        MODE_RUN: begin
          if (bus.stop_i) begin
            mode <= MODE_HALT;
          end
        end
        MODE_HALT: begin
          if (bus.stop_i) begin
            mode  <= MODE_PROG;
            state <= RST_ST;
          end else if (bus.start_i) begin
            mode <= MODE_RUN;
          end
        end
        default: begin
          mode  <= MODE_PROG;
          state <= RST_ST;
        end
      endcase
    end
  end

`ifdef FSM_TRACE_EN
  logic [15:0]        trans_cnt;
  logic [STATE_W-1:0] last_state;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      trans_cnt  <= '0;
      last_state <= RST_ST;
    end else if ((mode == MODE_PROG) && bus.start_i) begin
      trans_cnt <= '0;
    end else if (advance) begin
      last_state <= state;
      if (trans_cnt != 16'hFFFF) begin
        trans_cnt <= trans_cnt + 16'd1;
      end
    end
  end

  assign bus.trans_cnt    = trans_cnt;
  assign bus.last_state_o = last_state;
`endif

endmodule

// File: tb/tb_table_fsm_engine.sv
// Self-checking bench for table_fsm_engine: directed scenarios plus randomized traffic against a reference model.
// Defining FSM_TRACE_EN also checks trans_cnt / last_state_o including counter saturation.
module tb_table_fsm_engine;
  import table_fsm_engine_pkg::*;

  localparam int SW      = DEF_STATE_W;
  localparam int IW      = DEF_IN_W;
  localparam int OW      = DEF_OUT_W;
  localparam int NS      = DEF_NUM_STATES;
  localparam int RS      = DEF_RESET_STATE;
  localparam int ENTRIES = 1 << (SW + IW);

  logic clk = 1'b0;
  logic res = 1'b1;

  table_fsm_engine_if bus ();

  table_fsm_engine dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode as 0/1/2, state as plain int, table as a flat array.
  logic [SW+OW-1:0] tbl [ENTRIES];
  int m_mode  = 0;
  int m_state = RS;
  int m_last  = RS;
  int m_cnt   = 0;
  bit m_ill   = 1'b0;
  bit m_perr  = 1'b0;

  string pin_name [$];
  int    pin_sel  [$];
  int    pin_want [$];

  function automatic int entryNext(int s, int xi);
    logic [SW+OW-1:0] e;
    e = tbl[(s << IW) | xi];
    return int'(e[SW+OW-1:OW]);
  endfunction

  function automatic int entryOuts(int s, int xi);
    logic [SW+OW-1:0] e;
    e = tbl[(s << IW) | xi];
    return int'(e[OW-1:0]);
  endfunction

  function automatic bit modelAdvance();
    return (m_mode == 1) || (m_mode == 2 && bus.step_i && !bus.stop_i && !bus.start_i);
  endfunction

  // 11-state x/y automaton; {state 3, x=01} deliberately points at illegal state 15.
  function automatic logic [SW+OW-1:0] autoEntry(int s, int xi);
    int n;
    int o;
    n = (s * 3 + xi * 2 + 2) % NS;
    if (s == 3 && xi == 1) n = 15;
    o = 1 << ((s + xi) % OW);
    return {SW'(n), OW'(o)};
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_mode  <= 0;
      m_state <= RS;
      m_ill   <= 1'b0;
      m_perr  <= 1'b0;
      m_cnt   <= 0;
      m_last  <= RS;
    end else begin
      if (bus.prog_we) begin
        if (m_mode == 0) tbl[bus.prog_addr] <= bus.prog_data;
        else m_perr <= 1'b1;
      end
      if (modelAdvance()) begin
        m_last <= m_state;
        m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        if (entryNext(m_state, int'(bus.x_in)) >= NS) begin
          m_state <= RS;
          m_ill   <= 1'b1;
        end else begin
          m_state <= entryNext(m_state, int'(bus.x_in));
        end
      end
      if (m_mode == 0 && bus.start_i) begin
        m_mode  <= 1;
        m_state <= RS;
        m_cnt   <= 0;
      end else if (m_mode == 1 && bus.stop_i) begin
        m_mode <= 2;
      end else if (m_mode == 2 && bus.stop_i) begin
        m_mode  <= 0;
        m_state <= RS;
      end else if (m_mode == 2 && bus.start_i) begin
        m_mode <= 1;
      end
    end
  end

  function automatic logic [31:0] dutVal(int sel);
    case (sel)
      0: return 32'(bus.state_o);
      1: return 32'(bus.mode_o);
      2: return 32'(bus.t_out);
      3: return 32'(bus.t_valid);
      4: return 32'(bus.ill_err);
      5: return 32'(bus.prog_err);
`ifdef FSM_TRACE_EN
      6: return 32'(bus.trans_cnt);
      7: return 32'(bus.last_state_o);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", n, act, want, $time);
    end
  endtask

  // Single compare process: model check every live cycle, then any queued literal pins.
  always @(negedge clk) begin
    if (!res) begin
      checkOutput("t_valid", dutVal(3), 32'(modelAdvance()));
      checkOutput("t_out", dutVal(2),
                  modelAdvance() ? 32'(entryOuts(m_state, int'(bus.x_in))) : 32'd0);
      checkOutput("state_o", dutVal(0), 32'(m_state));
      checkOutput("mode_o", dutVal(1), 32'(m_mode));
      checkOutput("ill_err", dutVal(4), 32'(m_ill));
      checkOutput("prog_err", dutVal(5), 32'(m_perr));
`ifdef FSM_TRACE_EN
      checkOutput("trans_cnt", dutVal(6), 32'(m_cnt));
      checkOutput("last_state_o", dutVal(7), 32'(m_last));
`endif
    end
    while (pin_name.size() > 0) begin
      string n;
      int    s;
      int    w;
      n = pin_name.pop_front();
      s = pin_sel.pop_front();
      w = pin_want.pop_front();
      checkOutput(n, dutVal(s), 32'(w));
    end
  end

  task automatic applyStimulus(input logic [1:0] x, input logic st, input logic sp, input logic sn,
                               input logic we, input logic [SW+IW-1:0] addr,
                               input logic [SW+OW-1:0] data);
    bus.x_in      = x;
    bus.start_i   = st;
    bus.stop_i    = sp;
    bus.step_i    = sn;
    bus.prog_we   = we;
    bus.prog_addr = addr;
    bus.prog_data = data;
  endtask

  task automatic expectPin(input string n, input int sel, input int want);
    pin_name.push_back(n);
    pin_sel.push_back(sel);
    pin_want.push_back(want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    res = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    expectPin("rst_state", 0, 0);
    expectPin("rst_mode", 1, 0);
    expectPin("rst_t_out", 2, 0);
    expectPin("rst_t_valid", 3, 0);
    expectPin("rst_ill_err", 4, 0);
    expectPin("rst_prog_err", 5, 0);
    tick();
    res = 1'b0;

    $display("[TB] loading 11-state x/y automaton");
    for (int a = 0; a < ENTRIES; a++) begin
      applyStimulus(2'b00, 0, 0, 0, 1, (SW+IW)'(a), autoEntry(a >> IW, a & 3));
      tick();
    end

    applyStimulus(2'b10, 1, 0, 0, 0, '0, '0);
    expectPin("start_no_advance", 3, 0);
    tick();
    applyStimulus(2'b10, 0, 0, 0, 0, '0, '0);
    expectPin("run_mode", 1, 1);
    expectPin("run_first_valid", 3, 1);
    expectPin("run_first_t_out", 2, 'h004);
    tick();
    applyStimulus(2'b10, 0, 0, 0, 0, '0, '0);
    expectPin("run_state_6", 0, 6);
    expectPin("run_t_out_s6", 2, 'h100);
    tick();
    applyStimulus(2'b11, 0, 0, 0, 0, '0, '0);
    expectPin("run_state_2", 0, 2);
    tick();
    applyStimulus(2'b01, 0, 1, 0, 0, '0, '0);
    expectPin("run_state_3", 0, 3);
    expectPin("stop_cycle_advances", 3, 1);
    expectPin("stop_cycle_t_out", 2, 'h010);
    tick();

    $display("[TB] halt, illegal recovery and single step");
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    expectPin("illegal_to_reset", 0, 0);
    expectPin("ill_err_set", 4, 1);
    expectPin("halt_mode", 1, 2);
    expectPin("halt_idle_t_out", 2, 0);
    tick();
    tick();
    expectPin("halt_held_state", 0, 0);
    tick();
    applyStimulus(2'b00, 0, 0, 1, 0, '0, '0);
    expectPin("step_valid", 3, 1);
    expectPin("step_t_out", 2, 'h001);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    expectPin("step_state_2", 0, 2);
    expectPin("step_one_shot", 3, 0);
    tick();

    $display("[TB] resume, write attempt outside PROG");
    applyStimulus(2'b00, 1, 0, 0, 0, '0, '0);
    expectPin("halt_start_no_adv", 3, 0);
    tick();
    applyStimulus(2'b10, 0, 0, 0, 1, (SW+IW)'(2), '1);
    expectPin("resume_state_kept", 0, 2);
    expectPin("resume_mode_run", 1, 1);
    tick();
    applyStimulus(2'b00, 0, 1, 0, 0, '0, '0);
    expectPin("prog_err_set", 5, 1);
    expectPin("run_state_1", 0, 1);
    tick();
    applyStimulus(2'b00, 0, 1, 0, 0, '0, '0);
    expectPin("halt_state_5", 0, 5);
    tick();
    applyStimulus(2'b10, 1, 0, 0, 0, '0, '0);
    expectPin("back_to_prog", 1, 0);
    expectPin("prog_state_reset", 0, 0);
    tick();
    applyStimulus(2'b10, 0, 0, 0, 0, '0, '0);
    expectPin("entry_unchanged", 2, 'h004);
    tick();
    applyStimulus(2'b00, 0, 1, 0, 0, '0, '0);
    expectPin("entry_unchanged_next", 0, 6);
    tick();
    applyStimulus(2'b00, 1, 1, 0, 0, '0, '0);
    expectPin("coincide_state", 0, 9);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    expectPin("stop_beats_start", 1, 0);
    expectPin("stop_beats_start_state", 0, 0);
    expectPin("ill_err_sticky", 4, 1);
    expectPin("prog_err_sticky", 5, 1);
    tick();

    $display("[TB] asynchronous reset in RUN");
    applyStimulus(2'b10, 1, 0, 0, 0, '0, '0);
    tick();
    applyStimulus(2'b10, 0, 0, 0, 0, '0, '0);
    #1;
    res = 1'b1;
    expectPin("async_t_out", 2, 0);
    expectPin("async_t_valid", 3, 0);
    expectPin("async_mode", 1, 0);
    expectPin("async_state", 0, 0);
    expectPin("async_ill_clr", 4, 0);
    expectPin("async_perr_clr", 5, 0);
    tick();
    res = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
        res = 1'b1;
        tick();
        res = 1'b0;
      end else begin
        r = $urandom_range(0, 99);
        applyStimulus(2'($urandom), r < 6, r >= 6 && r < 10, r >= 10 && r < 30,
                      $urandom_range(0, 19) == 0, (SW+IW)'($urandom), (SW+OW)'($urandom));
        tick();
      end
    end

`ifdef FSM_TRACE_EN
    $display("[TB] trace counter saturation");
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    res = 1'b1;
    tick();
    res = 1'b0;
    applyStimulus(2'b00, 1, 0, 0, 0, '0, '0);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(2'($urandom), 0, 0, 0, 0, '0, '0);
      tick();
    end
    expectPin("trans_cnt_saturated", 6, 'hFFFF);
    tick();
`endif

    applyStimulus(2'b00, 0, 0, 0, 0, '0, '0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
